wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Shares the CPU's single Wishbone master port between three internal requesters: index 0 = instruction fetcher, 1 = load unit, 2 = store unit.
- Grants the bus by round-robin or fixed priority and locks the grant for the winner's entire cyc.
- Routes ack/err only to the owner.
- A watchdog terminates a stalled cycle with a synthetic error so the core never hangs.

Parameters:
- RR, 1, 1 = round-robin arbitration; 0 = fixed priority, index 0 highest.
- TIMEOUT_CYCLES, 255, number of wait cycles without ack/err before the watchdog fires; 0 disables the watchdog.
- TIMEOUT_W, 8, watchdog counter width; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_W.

Ports:
- i_clk  input  1  clock, all logic on the rising edge.
- i_reset_n  input  1  synchronous reset, active-low.
- i_req_cyc  input  3  per-requester cyc; bit n belongs to requester n.
- i_req_stb  input  12  per-requester byte strobes; [4n+3:4n] belongs to requester n.
- i_req_we  input  3  per-requester write enable.
- i_req_addr  input  96  per-requester address; [32n+31:32n].
- i_req_dat  input  96  per-requester write data; [32n+31:32n].
- o_req_dat  output  32  read data; i_wb_dat broadcast to all requesters.
- o_req_ack  output  3  ack, returned only to the owner.
- o_req_err  output  3  err, returned only to the owner; includes watchdog errors.
- o_grant  output  3  one-hot current owner; 0 when the bus is not owned.
- o_wb_addr  output  32  bus address.
- o_wb_cyc  output  1  bus cyc.
- o_wb_stb  output  4  bus byte strobes.
- o_wb_we  output  1  bus write enable.
- o_wb_dat  output  32  bus write data.
- i_wb_dat  input  32  bus read data.
- i_wb_ack  input  1  bus ack.
- i_wb_err  input  1  bus err.

Behaviour:
- States:
  - IDLE: no owner.
  - OWN: owner locked.
  - ABORT: watchdog fired; waiting for the owner to drop cyc.
- Reset (i_reset_n=0 at a clock edge):
  - State = IDLE, o_grant = 0, watchdog = 0.
  - RR pointer set so that requester 0 is checked first.
  - Reset wins over every other event, including mid-cycle. All bus outputs are 0 the cycle after reset.
- Bus outputs:
  - Combinational mux of the owner's signals in OWN.
  - In IDLE and ABORT: o_wb_cyc = 0, o_wb_stb = 0, o_wb_we = 0, o_wb_addr = 0, o_wb_dat = 0.
  - o_req_dat = i_wb_dat at all times.
- IDLE:
  - If any i_req_cyc bit is set, select a winner, register o_grant and go to OWN.
  - Arbitration latency: 1 cycle from request to o_wb_cyc.
  - RR=1: search starts at (last owner + 1) mod 3.
  - RR=0: lowest set index wins.
- OWN:
  - o_req_ack[n] = i_wb_ack & ~i_wb_err; o_req_err[n] = i_wb_err. Both are 0 for non-owners.
  - Bus ack/err are ignored in IDLE.
  - Simultaneous ack and err: err wins, ack is masked.
  - Grant holds across multi-beat cycles (e.g. a two-word instruction fetch) for as long as the owner holds cyc.
  - When the owner's cyc is low: go to IDLE, record the owner as last owner, clear o_grant. Bus cyc follows the owner combinationally, so it drops in the same cycle.
  - No pre-emption. Other requests wait in IDLE arbitration; at least one idle cycle separates consecutive owners.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counts cycles in OWN with the owner's stb ≠ 0 and no ack/err.
  - Clears on ack, err, stb = 0, or leaving OWN.
  - When the count reaches TIMEOUT_CYCLES: pulse o_req_err[owner] for exactly one cycle, drive o_wb_cyc low from the next cycle, and go to ABORT.
- ABORT:
  - Bus ack/err are ignored.
  - Stay until the owner's cyc is low, then go to IDLE; last owner is updated.
- Owner raises cyc with stb = 0: bus cyc is asserted with no strobe; this is legal and the watchdog does not count.

Test Plan:
- Single requester: i_req_cyc=3'b010, stb=4'hF, addr=0x100, slave acks 2 cycles after o_wb_cyc → o_grant=3'b010 one cycle after request; o_wb_addr=0x100; o_req_ack=3'b010 for one cycle; o_req_ack[0] and o_req_ack[2] stay 0.
- Round-robin with RR=1: all three cyc held high, each requester drops cyc after one ack → grant order 0,1,2,0, each grant separated by one IDLE cycle. With RR=0 the same stimulus → requester 0 wins repeatedly.
- Lock: fetcher owns the bus and does two beats (addr 0x0 then 0x4) while load requests → grant stays 3'b001 across both acks; load is granted only after fetcher cyc drops.
- Ack+err together: i_wb_ack=i_wb_err=1 for owner 2 → o_req_err=3'b100, o_req_ack=0.
- Watchdog with TIMEOUT_CYCLES=4: owner 1 strobes and the slave never acks → o_req_err[1] pulses exactly once, 4 stall cycles after the first strobe; o_wb_cyc=0 the next cycle; the arbiter holds ABORT until i_req_cyc[1]=0, then serves a pending requester 2.
- Reset mid-cycle: i_reset_n=0 while requester 0 is stalled in OWN → next cycle o_grant=0, o_wb_cyc=0; after release with all three requesting, requester 0 wins first.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone master-side bus between the arbiter and the single shared slave port.
// Signal names mirror the arbiter's bus pins; master drives o_*, slave drives i_*.
interface wb_bus_arbiter_if;
  logic [31:0] o_wb_addr;
  logic        o_wb_cyc;
  logic [3:0]  o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_dat;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat,
    output i_wb_dat, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Three-way Wishbone arbiter (fetch/load/store) with cycle-locked grant and a
// stall watchdog that aborts a hung cycle with a synthetic error.
module wb_bus_arbiter #(
  parameter bit          RR             = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [2:0]              i_req_cyc,
  input  logic [11:0]             i_req_stb,
  input  logic [2:0]              i_req_we,
  input  logic [95:0]             i_req_addr,
  input  logic [95:0]             i_req_dat,
  output logic [31:0]             o_req_dat,
  output logic [2:0]              o_req_ack,
  output logic [2:0]              o_req_err,
  output logic [2:0]              o_grant,
  wb_bus_arbiter_if.master        wb
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StOwn   = 2'd1;
  localparam logic [1:0] StAbort = 2'd2;

  localparam bit                   WdEn       = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TimeoutVal = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [1:0]           state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [1:0]           last_q, last_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

  logic        owner_cyc;
  logic        owner_we;
  logic [3:0]  owner_stb;
  logic [31:0] owner_addr;
  logic [31:0] owner_dat;
  logic [1:0]  owner_idx;

  logic [1:0]  start_idx;
  logic [2:0]  win_oh;
  logic        bus_en;
  logic        stalled;
  logic        wd_fire;

  // Owner's request signals, selected by the registered one-hot grant.
  always_comb begin
    owner_cyc  = 1'b0;
    owner_we   = 1'b0;
    owner_stb  = 4'h0;
    owner_addr = 32'h0;
    owner_dat  = 32'h0;
    owner_idx  = 2'd0;
    case (grant_q)
      3'b001: begin
        owner_cyc  = i_req_cyc[0];
        owner_we   = i_req_we[0];
        owner_stb  = i_req_stb[3:0];
        owner_addr = i_req_addr[31:0];
        owner_dat  = i_req_dat[31:0];
        owner_idx  = 2'd0;
      end
      3'b010: begin
        owner_cyc  = i_req_cyc[1];
        owner_we   = i_req_we[1];
        owner_stb  = i_req_stb[7:4];
        owner_addr = i_req_addr[63:32];
        owner_dat  = i_req_dat[63:32];
        owner_idx  = 2'd1;
      end
      3'b100: begin
        owner_cyc  = i_req_cyc[2];
        owner_we   = i_req_we[2];
        owner_stb  = i_req_stb[11:8];
        owner_addr = i_req_addr[95:64];
        owner_dat  = i_req_dat[95:64];
        owner_idx  = 2'd2;
      end
      default: ;
    endcase
  end

  // Search order starts just after the last owner in round-robin mode.
  always_comb begin
    start_idx = 2'd0;
    if (RR) start_idx = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    win_oh = 3'b000;
    case (start_idx)
      2'd1: begin
        if      (i_req_cyc[1]) win_oh = 3'b010;
        else if (i_req_cyc[2]) win_oh = 3'b100;
        else if (i_req_cyc[0]) win_oh = 3'b001;
      end
      2'd2: begin
        if      (i_req_cyc[2]) win_oh = 3'b100;
        else if (i_req_cyc[0]) win_oh = 3'b001;
        else if (i_req_cyc[1]) win_oh = 3'b010;
      end
      default: begin
        if      (i_req_cyc[0]) win_oh = 3'b001;
        else if (i_req_cyc[1]) win_oh = 3'b010;
        else if (i_req_cyc[2]) win_oh = 3'b100;
      end
    endcase
  end

  assign bus_en  = (state_q == StOwn);
  assign stalled = bus_en && owner_cyc && (owner_stb != 4'h0) && !wb.i_wb_ack && !wb.i_wb_err;
  assign wd_fire = WdEn && stalled && (wd_cnt_q == TimeoutVal);

  always_comb begin
    wd_cnt_d = '0;
    if (WdEn && stalled && !wd_fire) wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (|i_req_cyc) begin
          grant_d = win_oh;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (!owner_cyc) begin
          state_d = StIdle;
          grant_d = 3'b000;
          last_d  = owner_idx;
        end else if (wd_fire) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        if (!owner_cyc) begin
          state_d = StIdle;
          grant_d = 3'b000;
          last_d  = owner_idx;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      grant_q  <= 3'b000;
      last_q   <= 2'd2;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign wb.o_wb_cyc  = bus_en & owner_cyc;
  assign wb.o_wb_stb  = bus_en ? owner_stb  : 4'h0;
  assign wb.o_wb_we   = bus_en & owner_we;
  assign wb.o_wb_addr = bus_en ? owner_addr : 32'h0;
  assign wb.o_wb_dat  = bus_en ? owner_dat  : 32'h0;

  // Err dominates ack; the watchdog error is merged into the owner's err.
  assign o_req_ack = bus_en ? (grant_q & {3{wb.i_wb_ack & ~wb.i_wb_err}}) : 3'b000;
  assign o_req_err = bus_en ? (grant_q & {3{wb.i_wb_err | wd_fire}}) : 3'b000;
  assign o_req_dat = wb.i_wb_dat;
  assign o_grant   = grant_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench: dut_a is round-robin with a 4-cycle watchdog, dut_b is fixed
// priority; both share the same requester and slave stimulus.
module tb_wb_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_cyc;
  logic [11:0] req_stb;
  logic [2:0]  req_we;
  logic [95:0] req_addr;
  logic [95:0] req_dat;
  logic [31:0] wb_rdat;
  logic        wb_ack;
  logic        wb_err;

  logic [31:0] rdat_a, rdat_b;
  logic [2:0]  ack_a, ack_b, err_a, err_b, grant_a, grant_b;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_order [4] = '{0, 1, 2, 0};

  wb_bus_arbiter_if wb_a ();
  wb_bus_arbiter_if wb_b ();

  assign wb_a.i_wb_dat = wb_rdat;
  assign wb_a.i_wb_ack = wb_ack;
  assign wb_a.i_wb_err = wb_err;
  assign wb_b.i_wb_dat = wb_rdat;
  assign wb_b.i_wb_ack = wb_ack;
  assign wb_b.i_wb_err = wb_err;

  wb_bus_arbiter #(.RR(1'b1), .TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut_a (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req_cyc  (req_cyc),
    .i_req_stb  (req_stb),
    .i_req_we   (req_we),
    .i_req_addr (req_addr),
    .i_req_dat  (req_dat),
    .o_req_dat  (rdat_a),
    .o_req_ack  (ack_a),
    .o_req_err  (err_a),
    .o_grant    (grant_a),
    .wb         (wb_a)
  );

  wb_bus_arbiter #(.RR(1'b0), .TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut_b (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_req_cyc  (req_cyc),
    .i_req_stb  (req_stb),
    .i_req_we   (req_we),
    .i_req_addr (req_addr),
    .i_req_dat  (req_dat),
    .o_req_dat  (rdat_b),
    .o_req_ack  (ack_b),
    .o_req_err  (err_b),
    .o_grant    (grant_b),
    .wb         (wb_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 2 time units after a rising edge; outputs are sampled 1 later.
  task automatic slot();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_cyc  = '0;
    req_stb  = '0;
    req_we   = '0;
    req_addr = '0;
    req_dat  = '0;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rdat  = '0;
    slot();
    slot();
    rst_n = 1'b1;
  endtask

  // All three hold cyc; each owner takes one ack, drops cyc for one cycle, then re-requests.
  task automatic run_rr(input bit fixed);
    logic [2:0] g;
    logic [2:0] a;
    int e;
    do_reset();
    req_cyc  = 3'b111;
    req_stb  = 12'hFFF;
    req_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    for (int i = 0; i < 4; i++) begin
      e = fixed ? 0 : rr_order[i];
      slot();
      settle();
      g = fixed ? grant_b : grant_a;
      check_eq(fixed ? "fp_grant" : "rr_grant", 32'(g), 32'(3'b001 << e));
      check_eq(fixed ? "fp_addr" : "rr_addr", fixed ? wb_b.o_wb_addr : wb_a.o_wb_addr,
               32'(e + 1) * 32'h1000);
      wb_ack = 1'b1;
      settle();
      a = fixed ? ack_b : ack_a;
      check_eq(fixed ? "fp_ack" : "rr_ack", 32'(a), 32'(3'b001 << e));
      slot();
      wb_ack  = 1'b0;
      req_cyc = req_cyc & ~(3'b001 << e);
      settle();
      check_eq(fixed ? "fp_cyc_drop" : "rr_cyc_drop",
               32'(fixed ? wb_b.o_wb_cyc : wb_a.o_wb_cyc), 32'd0);
      slot();
      req_cyc = 3'b111;
      settle();
      g = fixed ? grant_b : grant_a;
      check_eq(fixed ? "fp_idle_gap" : "rr_idle_gap", 32'(g), 32'd0);
    end
  endtask

  initial begin
    // Reset state, with requests asserted to show reset dominates.
    rst_n    = 1'b0;
    req_cyc  = 3'b111;
    req_stb  = 12'hFFF;
    req_we   = 3'b111;
    req_addr = {3{32'h1234_5678}};
    req_dat  = {3{32'h9ABC_DEF0}};
    wb_ack   = 1'b1;
    wb_err   = 1'b0;
    wb_rdat  = 32'h0;
    slot();
    slot();
    settle();
    check_eq("rst_grant", 32'(grant_a), 32'd0);
    check_eq("rst_cyc", 32'(wb_a.o_wb_cyc), 32'd0);
    check_eq("rst_stb", 32'(wb_a.o_wb_stb), 32'd0);
    check_eq("rst_addr", wb_a.o_wb_addr, 32'd0);
    check_eq("rst_we", 32'(wb_a.o_wb_we), 32'd0);
    check_eq("rst_ack", 32'(ack_a), 32'd0);

    // Single requester 1, slave acks 2 cycles after bus cyc.
    do_reset();
    req_cyc           = 3'b010;
    req_stb[7:4]      = 4'hF;
    req_addr[63:32]   = 32'h0000_0100;
    settle();
    check_eq("t1_pre_grant", 32'(grant_a), 32'd0);
    slot();
    settle();
    check_eq("t1_grant", 32'(grant_a), 32'b010);
    check_eq("t1_cyc", 32'(wb_a.o_wb_cyc), 32'd1);
    check_eq("t1_addr", wb_a.o_wb_addr, 32'h100);
    check_eq("t1_stb", 32'(wb_a.o_wb_stb), 32'hF);
    slot();
    settle();
    check_eq("t1_no_ack_yet", 32'(ack_a), 32'd0);
    slot();
    wb_ack  = 1'b1;
    wb_rdat = 32'hDEAD_BEEF;
    settle();
    check_eq("t1_ack", 32'(ack_a), 32'b010);
    check_eq("t1_rdat", rdat_a, 32'hDEAD_BEEF);
    slot();
    wb_ack  = 1'b0;
    req_cyc = 3'b000;
    settle();
    check_eq("t1_ack_pulse", 32'(ack_a), 32'd0);
    check_eq("t1_cyc_drop", 32'(wb_a.o_wb_cyc), 32'd0);
    slot();
    settle();
    check_eq("t1_idle", 32'(grant_a), 32'd0);

    // Round-robin order 0,1,2,0 then fixed priority always 0.
    run_rr(1'b0);
    run_rr(1'b1);

    // Lock: fetcher does two beats while load waits.
    do_reset();
    req_cyc         = 3'b001;
    req_stb         = 12'h0FF;
    req_addr        = {32'h0, 32'h0000_2000, 32'h0};
    slot();
    wb_ack  = 1'b1;
    req_cyc = 3'b011;
    settle();
    check_eq("lk_grant0", 32'(grant_a), 32'b001);
    check_eq("lk_ack0", 32'(ack_a), 32'b001);
    slot();
    wb_ack         = 1'b0;
    req_addr[31:0] = 32'h4;
    settle();
    check_eq("lk_grant_hold", 32'(grant_a), 32'b001);
    check_eq("lk_addr1", wb_a.o_wb_addr, 32'h4);
    slot();
    wb_ack = 1'b1;
    settle();
    check_eq("lk_ack1", 32'(ack_a), 32'b001);
    check_eq("lk_grant1", 32'(grant_a), 32'b001);
    slot();
    wb_ack  = 1'b0;
    req_cyc = 3'b010;
    settle();
    check_eq("lk_cyc_drop", 32'(wb_a.o_wb_cyc), 32'd0);
    slot();
    settle();
    check_eq("lk_idle", 32'(grant_a), 32'd0);
    slot();
    settle();
    check_eq("lk_load_grant", 32'(grant_a), 32'b010);
    check_eq("lk_load_addr", wb_a.o_wb_addr, 32'h2000);
    req_cyc = 3'b000;
    slot();
    slot();

    // Simultaneous ack and err for a store by requester 2.
    req_cyc          = 3'b100;
    req_stb          = 12'hF00;
    req_we           = 3'b100;
    req_addr[95:64]  = 32'h0000_3000;
    req_dat[95:64]   = 32'hCAFE_F00D;
    slot();
    wb_ack = 1'b1;
    wb_err = 1'b1;
    settle();
    check_eq("ae_grant", 32'(grant_a), 32'b100);
    check_eq("ae_we", 32'(wb_a.o_wb_we), 32'd1);
    check_eq("ae_wdat", wb_a.o_wb_dat, 32'hCAFE_F00D);
    check_eq("ae_err", 32'(err_a), 32'b100);
    check_eq("ae_ack_masked", 32'(ack_a), 32'd0);
    slot();
    wb_ack  = 1'b0;
    wb_err  = 1'b0;
    req_cyc = 3'b000;
    req_we  = 3'b000;
    slot();

    // Watchdog: requester 1 stalls, requester 2 waits behind it.
    req_cyc = 3'b010;
    req_stb = 12'hFF0;
    slot();
    req_cyc = 3'b110;
    settle();
    check_eq("wd_grant", 32'(grant_a), 32'b010);
    check_eq("wd_err_s0", 32'(err_a), 32'd0);
    for (int k = 1; k < 4; k++) begin
      slot();
      settle();
      check_eq("wd_err_early", 32'(err_a), 32'd0);
    end
    slot();
    settle();
    check_eq("wd_fire", 32'(err_a), 32'b010);
    check_eq("wd_fire_cyc", 32'(wb_a.o_wb_cyc), 32'd1);
    slot();
    settle();
    check_eq("wd_err_once", 32'(err_a), 32'd0);
    check_eq("wd_abort_cyc", 32'(wb_a.o_wb_cyc), 32'd0);
    slot();
    wb_ack = 1'b1;
    settle();
    check_eq("wd_abort_ack", 32'(ack_a), 32'd0);
    check_eq("wd_abort_hold_cyc", 32'(wb_a.o_wb_cyc), 32'd0);
    slot();
    wb_ack  = 1'b0;
    req_cyc = 3'b100;
    settle();
    check_eq("wd_abort_exit_cyc", 32'(wb_a.o_wb_cyc), 32'd0);
    slot();
    settle();
    check_eq("wd_idle", 32'(grant_a), 32'd0);
    slot();
    settle();
    check_eq("wd_next_grant", 32'(grant_a), 32'b100);
    check_eq("wd_next_addr", wb_a.o_wb_addr, 32'h3000);
    req_cyc = 3'b000;
    slot();
    slot();

    // Reset while requester 0 is stalled in a cycle.
    req_cyc        = 3'b001;
    req_stb        = 12'h00F;
    req_addr[31:0] = 32'h40;
    slot();
    settle();
    check_eq("mr_grant", 32'(grant_a), 32'b001);
    slot();
    rst_n = 1'b0;
    slot();
    settle();
    check_eq("mr_grant_clr", 32'(grant_a), 32'd0);
    check_eq("mr_cyc", 32'(wb_a.o_wb_cyc), 32'd0);
    check_eq("mr_stb", 32'(wb_a.o_wb_stb), 32'd0);
    check_eq("mr_addr", wb_a.o_wb_addr, 32'd0);
    req_cyc = 3'b111;
    req_stb = 12'hFFF;
    rst_n   = 1'b1;
    slot();
    settle();
    check_eq("mr_first_winner", 32'(grant_a), 32'b001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
